// File: rtl/cga_pkg.sv
// Shared constants and state encoding for the CGA VRAM arbiter.
package cga_pkg;

    localparam int          VRAM_AW  = 14;
    localparam logic [4:0]  WIN_BASE = 5'b10111;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } arb_state_e;

    function automatic logic in_window(input logic [19:0] a, input logic aen);
        return !aen && (a[19:15] == WIN_BASE);
    endfunction

endpackage

// File: rtl/cga_isa_sync.sv
// Two-flop synchroniser with falling-edge detect for an async ISA strobe.
module cga_isa_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe_l_i,
    output logic sync_l_o,
    output logic fall_o
);

    logic [2:0] sh_q;
    logic [2:0] sh_d;

    assign sh_d     = {sh_q[1:0], strobe_l_i};
    assign sync_l_o = sh_q[1];
    assign fall_o   = sh_q[2] & ~sh_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_q <= 3'b111;
        end else begin
            sh_q <= sh_d;
        end
    end

endmodule

// File: rtl/cga_vram_arbiter.sv
// VRAM arbiter: display fetch always wins, CPU ops run in sequencer slots.
// Optional VRAM_WRITE_POST_EN posts CPU writes without stalling IOCHRDY.
module cga_vram_arbiter
    import cga_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [19:0]        bus_a,
    input  logic [7:0]         bus_d_in,
    input  logic               bus_memr_l,
    input  logic               bus_memw_l,
    input  logic               bus_aen,
    input  logic               isa_op_enable,
    input  logic               vram_read,
    input  logic               vram_read_a0,
    input  logic [12:0]        disp_addr,
    output logic               bus_rdy,
    output logic [7:0]         bus_d_out,
    output logic               bus_d_oe,
    output logic [VRAM_AW-1:0] ram_a,
    output logic [7:0]         ram_d_out,
    output logic               ram_d_oe,
    input  logic [7:0]         ram_d_in,
    output logic               ram_ce_l,
    output logic               ram_oe_l,
    output logic               ram_we_l
);

    arb_state_e         state_q, state_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               is_wr_q, is_wr_d;
    logic               own_q, own_d;
    logic               req_q, req_d;
    logic               req_wr_q, req_wr_d;

    logic rd_s, rd_fall, wr_s, wr_fall;
    logic sel, new_req, one_lo, post_ok;
    logic unused_a14;

    assign unused_a14 = bus_a[14];

    cga_isa_sync u_rd_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .strobe_l_i (bus_memr_l),
        .sync_l_o   (rd_s),
        .fall_o     (rd_fall)
    );

    cga_isa_sync u_wr_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .strobe_l_i (bus_memw_l),
        .sync_l_o   (wr_s),
        .fall_o     (wr_fall)
    );

    assign sel     = in_window(bus_a, bus_aen);
    // Both strobes low together is not a legal cycle, so it never starts.
    assign new_req = sel & ((rd_fall & wr_s) | (wr_fall & rd_s));
    assign one_lo  = bus_memr_l ^ bus_memw_l;

`ifdef VRAM_WRITE_POST_EN
    assign post_ok = ~bus_memw_l &
                     (((state_q == IDLE) & ~req_q) | (own_q & is_wr_q));
`else
    assign post_ok = 1'b0;
`endif

    assign bus_rdy   = ~(sel & one_lo & ~((state_q == DONE) & own_q) & ~post_ok);
    assign bus_d_oe  = sel & ~bus_memr_l;
    assign bus_d_out = rdata_q;
    assign ram_d_out = data_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        is_wr_d  = is_wr_q;
        own_d    = own_q;
        req_d    = req_q;
        req_wr_d = req_wr_q;

        // own_q tracks whether the CPU is still holding the strobe of this op.
        if (own_q && (is_wr_q ? wr_s : rd_s)) begin
            own_d = 1'b0;
        end
        if (new_req && state_q != IDLE) begin
            req_d    = 1'b1;
            req_wr_d = wr_fall;
        end

        unique case (state_q)
            IDLE: begin
                if (new_req || req_q) begin
                    addr_d  = bus_a[VRAM_AW-1:0];
                    data_d  = bus_d_in;
                    is_wr_d = new_req ? wr_fall : req_wr_q;
                    own_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (isa_op_enable && !vram_read) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = vram_read ? PEND : STROBE;
            end
            STROBE: begin
                state_d = vram_read ? PEND : HOLD;
            end
            HOLD: begin
                if (vram_read) begin
                    state_d = PEND;
                end else begin
                    if (!is_wr_q) begin
                        rdata_d = ram_d_in;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!own_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ram_a    = addr_q;
        ram_ce_l = 1'b1;
        ram_oe_l = 1'b1;
        ram_we_l = 1'b1;
        ram_d_oe = 1'b0;

        unique case (state_q)
            SETUP: begin
                ram_ce_l = 1'b0;
                ram_d_oe = is_wr_q;
            end
            STROBE: begin
                ram_ce_l = 1'b0;
                ram_d_oe = is_wr_q;
                ram_we_l = ~is_wr_q;
                ram_oe_l = is_wr_q;
            end
            HOLD: begin
                ram_ce_l = 1'b0;
                ram_d_oe = is_wr_q;
                ram_oe_l = is_wr_q;
            end
            default: begin
                ram_ce_l = 1'b1;
            end
        endcase

        // Display fetch takes the RAM outright; a half-issued write is dropped.
        if (vram_read) begin
            ram_a    = {disp_addr, vram_read_a0};
            ram_ce_l = 1'b0;
            ram_oe_l = 1'b0;
            ram_we_l = 1'b1;
            ram_d_oe = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            is_wr_q  <= 1'b0;
            own_q    <= 1'b0;
            req_q    <= 1'b0;
            req_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            is_wr_q  <= is_wr_d;
            own_q    <= own_d;
            req_q    <= req_d;
            req_wr_q <= req_wr_d;
        end
    end

endmodule
